tlb_op_ctrl: RTL and testbench

Sequencer for LoongArch TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) retired at the write-back stage. Sits between the WB stage, the CSR file and the TLB array. Turns each WB-issued op into a timed sequence of TLB search, read and write accesses, then returns a one-cycle completion pulse so WB can retire and raise a refetch. INVTLB runs as a multi-cycle scan that clears the E bit of every matching entry.

---
 rtl/tlb_op_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB from WB.
// Define TLB_FILL_RANDOM_EN for a free-running fill index.
`timescale 1ns/1ps
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_type,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_vppn,
  input  logic [IDX_W-1:0] csr_tlbidx_index,
  input  logic [18:0]      csr_tlbehi_vppn,
  input  logic [9:0]       csr_asid,
  output logic [18:0]      tlb_s_vppn,
  output logic [9:0]       tlb_s_asid,
  input  logic             tlb_s_found,
  input  logic [IDX_W-1:0] tlb_s_index,
  output logic [IDX_W-1:0] tlb_r_index,
  input  logic             tlb_r_e,
  input  logic             tlb_r_g,
  input  logic [9:0]       tlb_r_asid,
  input  logic [18:0]      tlb_r_vppn,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic             tlb_inv_we,
  output logic             op_busy,
  output logic             op_done,
  output logic             op_err,
  output logic             srch_we,
  output logic             srch_found,
  output logic [IDX_W-1:0] srch_index,
  output logic             rd_we,
  output logic             refetch_req
);

  typedef enum logic [1:0] {IDLE, EXEC, SCAN, DONE} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  localparam logic [IDX_W:0]   LAST_I   = (IDX_W+1)'(TLBNUM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  state_t state, state_n;

  logic [2:0]       op_q;
  logic [4:0]       inv_op_q;
  logic [9:0]       inv_asid_q;
  logic [18:0]      inv_vppn_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] w_idx_q;
  logic [18:0]      key_vppn_q;
  logic [9:0]       key_asid_q;
  logic             err_q;
  logic [IDX_W:0]   scan_i;
  logic [IDX_W-1:0] fill_cnt;
  logic             found_q;
  logic [IDX_W-1:0] sidx_q;

  logic accept;
  logic inv_hit;
  logic asid_hit;
  logic vppn_hit;
  logic unused_e;

  assign accept   = (state == IDLE) && op_valid && (op_type <= OP_INV);
  assign asid_hit = (tlb_r_asid == inv_asid_q);
  assign vppn_hit = (tlb_r_vppn == inv_vppn_q);
  // E is deliberately ignored: clearing an already-invalid entry is harmless.
  assign unused_e = tlb_r_e;

  always_comb begin
    inv_hit = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = tlb_r_g;
      5'd3:       inv_hit = !tlb_r_g;
      5'd4:       inv_hit = !tlb_r_g && asid_hit;
      5'd5:       inv_hit = !tlb_r_g && asid_hit && vppn_hit;
      5'd6:       inv_hit = (tlb_r_g || asid_hit) && vppn_hit;
      default:    inv_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (op_type != OP_INV) state_n = EXEC;
          else if (inv_op <= 5'd6) state_n = SCAN;
          else state_n = DONE;
        end
      end
      EXEC: state_n = DONE;
      SCAN: if (scan_i == LAST_I) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign op_busy     = (state != IDLE);
  assign op_done     = (state == DONE);
  assign op_err      = op_done && err_q;
  assign srch_we     = op_done && (op_q == OP_SRCH);
  assign rd_we       = op_done && (op_q == OP_RD);
  assign refetch_req = op_done && !err_q && (op_q >= OP_WR);
  assign tlb_we      = (state == EXEC) && ((op_q == OP_WR) || (op_q == OP_FILL));
  assign tlb_w_index = w_idx_q;
  assign tlb_inv_we  = (state == SCAN) && inv_hit;
  assign tlb_r_index = (state == SCAN) ? scan_i[IDX_W-1:0] : idx_q;
  assign tlb_s_vppn  = key_vppn_q;
  assign tlb_s_asid  = key_asid_q;
  assign srch_found  = found_q;
  assign srch_index  = sidx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      idx_q      <= '0;
      w_idx_q    <= '0;
      key_vppn_q <= '0;
      key_asid_q <= '0;
      err_q      <= 1'b0;
      scan_i     <= '0;
      fill_cnt   <= '0;
      found_q    <= 1'b0;
      sidx_q     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q       <= op_type;
        inv_op_q   <= inv_op;
        inv_asid_q <= inv_asid;
        inv_vppn_q <= inv_vppn;
        idx_q      <= csr_tlbidx_index;
        w_idx_q    <= (op_type == OP_FILL) ? fill_cnt : csr_tlbidx_index;
        key_vppn_q <= csr_tlbehi_vppn;
        key_asid_q <= csr_asid;
        err_q      <= (op_type == OP_INV) && (inv_op > 5'd6);
        scan_i     <= '0;
      end
      if (state == SCAN) scan_i <= scan_i + 1'b1;
      if ((state == EXEC) && (op_q == OP_SRCH)) begin
        found_q <= tlb_s_found;
        sidx_q  <= tlb_s_found ? tlb_s_index : '0;
      end
`ifdef TLB_FILL_RANDOM_EN
      fill_cnt <= (fill_cnt == LAST_IDX) ? '0 : fill_cnt + 1'b1;
`else
      if ((state == DONE) && (op_q == OP_FILL))
        fill_cnt <= (fill_cnt == LAST_IDX) ? '0 : fill_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized bench for tlb_op_ctrl with a TLB array model and
// an op-level reference model of latency, writes and invalidations.
`timescale 1ns/1ps
module tb_tlb_op_ctrl;
  localparam int N  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          op_valid = 1'b0;
  logic [2:0]    op_type = '0;
  logic [4:0]    inv_op = '0;
  logic [9:0]    inv_asid = '0;
  logic [18:0]   inv_vppn = '0;
  logic [IW-1:0] csr_tlbidx_index = '0;
  logic [18:0]   csr_tlbehi_vppn = '0;
  logic [9:0]    csr_asid = '0;
  logic          csr_g = 1'b0;
  logic [18:0]   tlb_s_vppn;
  logic [9:0]    tlb_s_asid;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic [IW-1:0] tlb_r_index;
  logic          tlb_r_e, tlb_r_g;
  logic [9:0]    tlb_r_asid;
  logic [18:0]   tlb_r_vppn;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic          tlb_inv_we;
  logic          op_busy, op_done, op_err;
  logic          srch_we, srch_found;
  logic [IW-1:0] srch_index;
  logic          rd_we, refetch_req;

  tlb_op_ctrl #(.TLBNUM(N), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .csr_tlbidx_index(csr_tlbidx_index),
    .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_asid(csr_asid),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g),
    .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_inv_we(tlb_inv_we),
    .op_busy(op_busy), .op_done(op_done), .op_err(op_err),
    .srch_we(srch_we), .srch_found(srch_found), .srch_index(srch_index),
    .rd_we(rd_we), .refetch_req(refetch_req)
  );

  // TLB array model; entries survive controller reset
  logic          tv_e[N];
  logic          tv_g[N];
  logic [9:0]    tv_asid[N];
  logic [18:0]   tv_vppn[N];
  logic          poke_en = 1'b0;
  logic [IW-1:0] poke_idx = '0;
  logic          poke_e = 1'b0, poke_g = 1'b0;
  logic [9:0]    poke_asid = '0;
  logic [18:0]   poke_vppn = '0;

  always @(posedge clk) begin
    if (poke_en) begin
      tv_e[poke_idx]    <= poke_e;
      tv_g[poke_idx]    <= poke_g;
      tv_asid[poke_idx] <= poke_asid;
      tv_vppn[poke_idx] <= poke_vppn;
    end
    if (tlb_we) begin
      tv_e[tlb_w_index]    <= 1'b1;
      tv_g[tlb_w_index]    <= csr_g;
      tv_asid[tlb_w_index] <= csr_asid;
      tv_vppn[tlb_w_index] <= csr_tlbehi_vppn;
    end
    if (tlb_inv_we) tv_e[tlb_r_index] <= 1'b0;
  end

  assign tlb_r_e    = tv_e[tlb_r_index];
  assign tlb_r_g    = tv_g[tlb_r_index];
  assign tlb_r_asid = tv_asid[tlb_r_index];
  assign tlb_r_vppn = tv_vppn[tlb_r_index];

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int j = N - 1; j >= 0; j--)
      if (tv_e[j] && tv_vppn[j] == tlb_s_vppn &&
          (tv_g[j] || tv_asid[j] == tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = IW'(j);
      end
  end

  int edge_cnt;
  always @(posedge clk or posedge reset)
    if (reset) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;
  int fill_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit inv_match(input int op, input logic g,
      input logic [9:0] a, input logic [18:0] v,
      input logic [9:0] ia, input logic [18:0] iv);
    bit ah = (a == ia);
    bit vh = (v == iv);
    case (op)
      0, 1:    return 1'b1;
      2:       return g;
      3:       return !g;
      4:       return !g && ah;
      5:       return !g && ah && vh;
      6:       return (g || ah) && vh;
      default: return 1'b0;
    endcase
  endfunction

  task automatic poke(input int idx, input logic e, input logic g,
                      input logic [9:0] a, input logic [18:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = IW'(idx);
    poke_e = e; poke_g = g; poke_asid = a; poke_vppn = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_op(input int ty, input int iop, input logic [9:0] ia,
      input logic [18:0] iv, input int cidx, input logic [18:0] cv,
      input logic [9:0] ca, input logic cg, input bit drop);
    logic se[N], sg[N], xe[N], xg[N];
    logic [9:0] sa[N], xa[N];
    logic [18:0] sv[N], xv[N];
    logic [N-1:0] exp_mask, got_mask;
    bit legal, err, efound, gerr, gref, gfound;
    int elat, ew, eidx, lat, nwe, wi, nsrch, nrd, gidx, bad, lim;
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      se[j] = tv_e[j]; sg[j] = tv_g[j]; sa[j] = tv_asid[j]; sv[j] = tv_vppn[j];
    end
    legal = (ty <= 4);
    err   = (ty == 4) && (iop > 6);
    elat  = !legal ? 0 : (ty == 4) ? (err ? 1 : N + 1) : 2;
`ifdef TLB_FILL_RANDOM_EN
    ew = (ty == 3) ? (edge_cnt % N) : cidx;
`else
    ew = (ty == 3) ? fill_ptr : cidx;
`endif
    efound = 1'b0; eidx = 0;
    for (int j = 0; j < N; j++)
      if (!efound && se[j] && sv[j] == cv && (sg[j] || sa[j] == ca)) begin
        efound = 1'b1; eidx = j;
      end
    for (int j = 0; j < N; j++) begin
      exp_mask[j] = (ty == 4) && !err && inv_match(iop, sg[j], sa[j], sv[j], ia, iv);
      xe[j] = se[j] && !exp_mask[j]; xg[j] = sg[j]; xa[j] = sa[j]; xv[j] = sv[j];
    end
    if (ty == 2 || ty == 3) begin
      xe[ew] = 1'b1; xg[ew] = cg; xa[ew] = ca; xv[ew] = cv;
    end
    op_valid = 1'b1; op_type = 3'(ty); inv_op = 5'(iop);
    inv_asid = ia; inv_vppn = iv; csr_tlbidx_index = IW'(cidx);
    csr_tlbehi_vppn = cv; csr_asid = ca; csr_g = cg;
    got_mask = '0; lat = 0; nwe = 0; wi = 0; nsrch = 0; nrd = 0;
    gerr = 0; gref = 0; gfound = 0; gidx = 0;
    lim = legal ? N + 6 : 3;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (drop && k == 1) op_valid = 1'b0;
      if (tlb_we) begin nwe++; wi = int'(tlb_w_index); end
      if (tlb_inv_we) got_mask[tlb_r_index] = 1'b1;
      if (srch_we) begin nsrch++; gfound = srch_found; gidx = int'(srch_index); end
      if (rd_we) begin
        nrd++;
        chk("rd_index", 32'(tlb_r_index), 32'(cidx));
        chk("rd_data", {tlb_r_e, tlb_r_g, tlb_r_asid, tlb_r_vppn},
            {se[cidx], sg[cidx], sa[cidx], sv[cidx]});
      end
      if (op_done) begin
        lat = k; gerr = op_err; gref = refetch_req;
        break;
      end
    end
    op_valid = 1'b0;
    chk("latency", 32'(lat), 32'(elat));
    if (legal) begin
      chk("op_err", 32'(gerr), 32'(err));
      chk("refetch", 32'(gref), 32'(ty >= 2 && !err));
      chk("srch_we_cnt", 32'(nsrch), 32'(ty == 0));
      chk("rd_we_cnt", 32'(nrd), 32'(ty == 1));
      chk("tlb_we_cnt", 32'(nwe), 32'(ty == 2 || ty == 3));
      chk("inv_mask", 32'(got_mask), 32'(exp_mask));
      if (ty == 0) begin
        chk("srch_found", 32'(gfound), 32'(efound));
        chk("srch_index", 32'(gidx), 32'(eidx));
      end
      if (ty == 2 || ty == 3) chk("w_index", 32'(wi), 32'(ew));
    end
    @(negedge clk);
    chk("back_idle", {30'd0, op_busy, op_done}, 32'd0);
    bad = 0;
    for (int j = 0; j < N; j++)
      if ({tv_e[j], tv_g[j], tv_asid[j], tv_vppn[j]} !==
          {xe[j], xg[j], xa[j], xv[j]}) bad++;
    chk("tlb_state", 32'(bad), 32'd0);
    if (ty == 3) fill_ptr = (fill_ptr + 1) % N;
  endtask

  task automatic reset_mid_scan();
    int bad, dones;
    for (int j = 0; j < N; j++) poke(j, 1'b1, 1'b0, 10'd1, 19'h1);
    @(negedge clk);
    op_valid = 1'b1; op_type = 3'd4; inv_op = 5'd0;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("scan_at_6", 32'(tlb_r_index), 32'd6);
    reset = 1'b1;
    #1;
    chk("rst_outs", {23'd0, op_busy, op_done, op_err, tlb_we, tlb_inv_we,
        srch_we, rd_we, refetch_req, srch_found}, 32'd0);
    chk("rst_idx", {24'd0, tlb_r_index, tlb_w_index}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fill_ptr = 0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (op_done || op_busy) dones++;
    end
    chk("no_done_after_rst", 32'(dones), 32'd0);
    bad = 0;
    for (int j = 0; j < N; j++)
      if (tv_e[j] !== (j >= 6)) bad++;
    chk("partial_clear", 32'(bad), 32'd0);
  endtask

  function automatic logic [18:0] pick_vppn();
    int r = $urandom_range(0, 3);
    case (r)
      0: return 19'h100;
      1: return 19'h101;
      2: return 19'h12345;
      default: return 19'($urandom);
    endcase
  endfunction

  initial begin
    for (int j = 0; j < N; j++) poke(j, 1'b0, 1'b0, 10'd0, 19'd0);
    #1;
    chk("reset_state", {22'd0, op_busy, op_done, op_err, tlb_we, tlb_inv_we,
        srch_we, rd_we, refetch_req, srch_found, 1'b0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    poke(9, 1'b1, 1'b0, 10'd5, 19'h12345);
    run_op(0, 0, 0, 0, 0, 19'h12345, 10'd5, 1'b0, 0);
    run_op(2, 0, 0, 0, 3, 19'h0abcd, 10'h2a, 1'b1, 0);
    run_op(1, 0, 0, 0, 3, 19'h0, 10'h0, 1'b0, 0);
    poke(2, 1'b1, 1'b0, 10'd7, 19'h100);
    poke(4, 1'b1, 1'b1, 10'h33, 19'h100);
    run_op(4, 5, 10'd7, 19'h100, 0, 19'h0, 10'd0, 1'b0, 1);
    run_op(4, 9, 10'd7, 19'h100, 0, 19'h0, 10'd0, 1'b0, 0);
    run_op(3, 0, 0, 0, 7, 19'h200, 10'd1, 1'b0, 0);
    run_op(3, 0, 0, 0, 7, 19'h201, 10'd1, 1'b1, 0);
    run_op(3, 0, 0, 0, 7, 19'h202, 10'd2, 1'b0, 1);
    run_op(6, 0, 0, 0, 1, 19'h0, 10'd0, 1'b0, 0);
    reset_mid_scan();
    run_op(0, 0, 0, 0, 0, 19'h1, 10'd1, 1'b0, 0);

    for (int j = 0; j < N; j++)
      poke(j, 1'($urandom), 1'($urandom), 10'($urandom_range(0, 3)), pick_vppn());
    for (int n = 0; n < 80; n++) begin
      int r, ty;
      r  = $urandom_range(0, 19);
      ty = (r < 18) ? (r % 5) : 5 + (r - 18);
      run_op(ty, $urandom_range(0, 8), 10'($urandom_range(0, 3)), pick_vppn(),
             $urandom_range(0, N - 1), pick_vppn(), 10'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
